cpu_clk_ctrl: RTL and testbench

Clock-enable and clock generator for the single-cycle CPU. It sits directly upstream of the CPU/DMEM pair and drives `clk_cpu` from the board clock. It supports free-running mode (fixed 50 % divide) and single-step mode, where each debounced button press produces exactly one full CPU clock pulse. It also provides a per-edge tick and an edge counter for the display/debug path.

---
 rtl/cpu_clk_ctrl.sv | 150 +++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// CPU clock generator: free-running 50 % divide or one debounced pulse per button press.
// Also produces a per-rising-edge tick and a wrapping edge counter for debug.
//
// state   | meaning
// STOP    | clk_cpu low, waiting for run mode or a pending step press
// RUN_HI  | free-run high phase (DIV_HALF cycles)
// RUN_LO  | free-run low phase (DIV_HALF cycles)
// STEP_HI | single-step high phase (DIV_HALF cycles)
module cpu_clk_ctrl #(
    parameter int DIV_HALF  = 50_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode_run,
    input  logic        step_btn,
    output logic        clk_cpu,
    output logic        cpu_tick,
    output logic [31:0] edge_cnt,
    output logic        running
);

    localparam int DW = $clog2(DIV_HALF + 1);
    localparam int BW = $clog2(DB_CYCLES);
    localparam logic [DW-1:0] DIV_TERM = DW'(DIV_HALF - 1);
    localparam logic [DW-1:0] DIV_FULL = DW'(DIV_HALF);
    localparam logic [BW-1:0] DB_TERM  = BW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {STOP, RUN_HI, RUN_LO, STEP_HI} state_t;

    state_t          state, nxt;
    logic            mode_m, mode_s;
    logic            btn_m, btn_s;
    logic            db_level, db_prev;
    logic [BW-1:0]   db_cnt;
    logic            press;
    logic            pend;
    logic [DW-1:0]   low_cnt;
    logic [DW-1:0]   div_cnt;
    logic            term;
    logic            low_full;
    logic            hi_nxt;
    logic            enter_hi;
    logic            pend_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_m <= 1'b0;
            mode_s <= 1'b0;
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            mode_m <= mode_run;
            mode_s <= mode_m;
            btn_m  <= step_btn;
            btn_s  <= btn_m;
        end
    end

    // Level only follows btn_s after it has differed for DB_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
            db_prev  <= 1'b0;
            press    <= 1'b0;
        end else begin
            if (btn_s == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_TERM) begin
                db_level <= btn_s;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + BW'(1);
            end
            db_prev <= db_level;
            press   <= db_level & ~db_prev;
        end
    end

    assign term     = (div_cnt == DIV_TERM);
    assign low_full = (low_cnt == DIV_FULL);

    always_comb begin
        nxt = state;
        case (state)
            STOP: begin
                if (mode_s && low_full)
                    nxt = RUN_HI;
                else if (pend && low_full)
                    nxt = STEP_HI;
            end
            RUN_HI:  if (term) nxt = RUN_LO;
            RUN_LO:  if (term) nxt = mode_s ? RUN_HI : STOP;
            STEP_HI: if (term) nxt = STOP;
            default: nxt = STOP;
        endcase
    end

    assign hi_nxt   = (nxt == RUN_HI) || (nxt == STEP_HI);
    assign enter_hi = hi_nxt && (nxt != state);
    assign pend_clr = (state == STOP) && (nxt != STOP);

    // A simultaneous new press outranks the clear so it is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend <= 1'b0;
        else if (press)
            pend <= 1'b1;
        else if (pend_clr)
            pend <= 1'b0;
    end

    // Counts the cycle of the falling edge itself, so a low phase of exactly DIV_HALF is allowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            low_cnt <= DIV_FULL;
        else if (hi_nxt)
            low_cnt <= '0;
        else if (!low_full)
            low_cnt <= low_cnt + DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if ((nxt != state) || (state == STOP))
            div_cnt <= '0;
        else if (!term)
            div_cnt <= div_cnt + DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STOP;
            clk_cpu  <= 1'b0;
            cpu_tick <= 1'b0;
            edge_cnt <= '0;
            running  <= 1'b0;
        end else begin
            state    <= nxt;
            clk_cpu  <= hi_nxt;
            cpu_tick <= enter_hi;
            running  <= (nxt == RUN_HI) || (nxt == RUN_LO);
            if (enter_hi)
                edge_cnt <= edge_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: free-run, single step, bounce, mode drop, reset mid-pulse,
// plus back-to-back presses on a second instance with a longer phase and shorter debounce.
module tb_cpu_clk_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mode_run;
    logic        step_btn;
    logic        clk_cpu, cpu_tick, running;
    logic [31:0] edge_cnt;
    logic        s_clk_cpu, s_cpu_tick, s_running;
    logic [31:0] s_edge_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;
    logic prev_cpu;

    cpu_clk_ctrl #(.DIV_HALF(4), .DB_CYCLES(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_run (mode_run),
        .step_btn (step_btn),
        .clk_cpu  (clk_cpu),
        .cpu_tick (cpu_tick),
        .edge_cnt (edge_cnt),
        .running  (running)
    );

    cpu_clk_ctrl #(.DIV_HALF(12), .DB_CYCLES(4)) dut_slow (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_run (mode_run),
        .step_btn (step_btn),
        .clk_cpu  (s_clk_cpu),
        .cpu_tick (s_cpu_tick),
        .edge_cnt (s_edge_cnt),
        .running  (s_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clk edge and sample 1 ns later; counts main clk_cpu rising edges.
    task automatic step();
        @(posedge clk);
        #1;
        if (clk_cpu && !prev_cpu) pulses++;
        prev_cpu = clk_cpu;
    endtask

    task automatic do_reset(input logic m);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        mode_run = m;
        step_btn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst clk_cpu", {31'd0, clk_cpu}, 32'd0);
        chk("rst cpu_tick", {31'd0, cpu_tick}, 32'd0);
        chk("rst edge_cnt", edge_cnt, 32'd0);
        chk("rst running", {31'd0, running}, 32'd0);
        rst_n    = 1'b1;
        pulses   = 0;
        prev_cpu = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        mode_run = 1'b0;
        step_btn = 1'b0;
        pulses   = 0;
        prev_cpu = 1'b0;

        // Free-run: rises at edge 3, period 8, high 4.
        do_reset(1'b1);
        for (int k = 1; k <= 40; k++) begin
            step();
            chk($sformatf("run clk_cpu k=%0d", k), {31'd0, clk_cpu},
                (k >= 3 && ((k - 3) % 8) < 4) ? 32'd1 : 32'd0);
            chk($sformatf("run tick k=%0d", k), {31'd0, cpu_tick},
                (k >= 3 && ((k - 3) % 8) == 0) ? 32'd1 : 32'd0);
            if (k == 3 || k == 40)
                chk($sformatf("run running k=%0d", k), {31'd0, running}, 32'd1);
            if (k == 35)
                chk("run edge_cnt", edge_cnt, 32'd5);
        end

        // Single step: clean press held 20 cycles -> high during edges 13..16.
        do_reset(1'b0);
        repeat (5) step();
        step_btn = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 21) step_btn = 1'b0;
            step();
            chk($sformatf("step clk_cpu k=%0d", k), {31'd0, clk_cpu},
                (k >= 13 && k <= 16) ? 32'd1 : 32'd0);
            chk($sformatf("step tick k=%0d", k), {31'd0, cpu_tick},
                (k == 13) ? 32'd1 : 32'd0);
            chk($sformatf("step running k=%0d", k), {31'd0, running}, 32'd0);
        end
        chk("step edge_cnt", edge_cnt, 32'd1);

        // Bounce: 3-cycle toggles then a steady hold -> one pulse; a short glitch -> none.
        do_reset(1'b0);
        for (int seg = 0; seg < 10; seg++) begin
            step_btn = (seg % 2 == 0);
            repeat (3) step();
        end
        chk("bounce no early pulse", pulses, 32'd0);
        step_btn = 1'b1;
        repeat (30) step();
        step_btn = 1'b0;
        repeat (30) step();
        chk("bounce pulses", pulses, 32'd1);
        chk("bounce edge_cnt", edge_cnt, 32'd1);
        step_btn = 1'b1;
        repeat (5) step();
        step_btn = 1'b0;
        repeat (40) step();
        chk("glitch pulses", pulses, 32'd1);
        chk("glitch edge_cnt", edge_cnt, 32'd1);

        // Mode drop during the first RUN_HI cycle: high and low complete, then STOP.
        do_reset(1'b1);
        for (int k = 1; k <= 30; k++) begin
            if (k == 4) mode_run = 1'b0;
            step();
            chk($sformatf("drop clk_cpu k=%0d", k), {31'd0, clk_cpu},
                (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
            chk($sformatf("drop running k=%0d", k), {31'd0, running},
                (k >= 3 && k <= 10) ? 32'd1 : 32'd0);
        end
        chk("drop edge_cnt", edge_cnt, 32'd1);

        // Back-to-back on DIV_HALF=12 / DB_CYCLES=4: second press captured during STEP_HI,
        // second pulse starts 12 cycles after the first falls, third press dropped.
        do_reset(1'b0);
        for (int k = 1; k <= 80; k++) begin
            step_btn = (k <= 8) || (k >= 13 && k <= 20) || (k >= 25 && k <= 30);
            step();
            chk($sformatf("b2b clk_cpu k=%0d", k), {31'd0, s_clk_cpu},
                ((k >= 9 && k <= 20) || (k >= 33 && k <= 44)) ? 32'd1 : 32'd0);
            if (k == 20)
                chk("b2b edge_cnt first", s_edge_cnt, 32'd1);
            if (k == 33)
                chk("b2b tick second", {31'd0, s_cpu_tick}, 32'd1);
        end
        chk("b2b edge_cnt", s_edge_cnt, 32'd2);
        chk("b2b running", {31'd0, s_running}, 32'd0);

        // Reset in the middle of STEP_HI: clk_cpu drops at once and nothing follows.
        do_reset(1'b0);
        step_btn = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            if (k == 13) step_btn = 1'b0;
            step();
        end
        chk("rstmid pre clk_cpu", {31'd0, clk_cpu}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid async clk_cpu", {31'd0, clk_cpu}, 32'd0);
        chk("rstmid edge_cnt", edge_cnt, 32'd0);
        step();
        rst_n    = 1'b1;
        pulses   = 0;
        prev_cpu = 1'b0;
        repeat (40) step();
        chk("rstmid pulses", pulses, 32'd0);
        chk("rstmid edge_cnt end", edge_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
